// File: rtl/reg_serial_tx.sv
// Parallel-to-serial transmitter for the Reg register link.
// Frames one WIDTH-bit word as: start(0), data bits, optional even parity, stop(1).
// Every serial-side output is registered; only load_ready is decoded from state.
module reg_serial_tx #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter bit LSB_FIRST    = 1'b1,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             tx_out_q, tx_out_d;
    logic             tx_busy_q, tx_busy_d;
    logic             tx_done_q, tx_done_d;
    logic             cyc_end;

    // The shift register rotates rather than shifts, so after WIDTH bit
    // periods it holds the latched word again and its XOR is still the parity.
    function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] v);
        if (LSB_FIRST) begin
            return (v >> 1) | (v << (WIDTH - 1));
        end else begin
            return (v << 1) | (v >> (WIDTH - 1));
        end
    endfunction

    // Bit currently presented on the line from the shift register.
    function automatic logic cur_bit(input logic [WIDTH-1:0] v);
        if (LSB_FIRST) begin
            return v[0];
        end else begin
            return v[WIDTH-1];
        end
    endfunction

    assign cyc_end    = (cyc_q == CYC_LAST);
    assign load_ready = (state_q == S_IDLE);
    assign tx_out     = tx_out_q;
    assign tx_busy    = tx_busy_q;
    assign tx_done    = tx_done_q;

    // State, counters, shift register and registered outputs; async reset aborts any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            tx_out_q  <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            tx_out_q  <= tx_out_d;
            tx_busy_q <= tx_busy_d;
            tx_done_q <= tx_done_d;
        end
    end

    // Next-state logic: each non-idle state holds for CLKS_PER_BIT cycles, DATA for WIDTH bits.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        case (state_q)
            S_IDLE: begin
                if (load_valid) begin
                    state_d = S_START;
                    shreg_d = d_in;
                    cyc_d   = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (cyc_end) begin
                    state_d = S_DATA;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cyc_end) begin
                    cyc_d   = '0;
                    shreg_d = rotate(shreg_q);
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (cyc_end) begin
                    state_d = S_STOP;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cyc_end) begin
                    state_d = S_IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so the line level is registered with zero extra latency.
    always_comb begin
        tx_out_d  = 1'b1;
        tx_busy_d = (state_d != S_IDLE);
        tx_done_d = (state_d == S_STOP) && (cyc_d == CYC_LAST);
        case (state_d)
            S_IDLE:   tx_out_d = 1'b1;
            S_START:  tx_out_d = 1'b0;
            S_DATA:   tx_out_d = cur_bit(shreg_d);
            S_PARITY: tx_out_d = ^shreg_d;
            S_STOP:   tx_out_d = 1'b1;
            default:  tx_out_d = 1'b1;
        endcase
    end

endmodule
